// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry and the address/word types that go with it.
// No ports; imported by the register file, its scoreboard and the bus interface.
package cpu_pkg;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_NUM_REGS = 16;
  localparam int unsigned DEF_NUM_RD   = 2;
  localparam int unsigned REG_AW       = $clog2(DEF_NUM_REGS);

  typedef logic [REG_AW-1:0]     reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, writeback port, claim port and scoreboard view.
// master: decode/writeback side (drives requests); slave: the register file.
//   rd_en/rd_addr -> rd_data/rd_busy   registered multi-port read
//   wr_en/wr_addr/wr_data              writeback
//   claim_en/claim_addr -> claim_ok    combinational destination grant
//   busy_vec                           current scoreboard
interface regfile_sb_if
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = DEF_NUM_RD
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic                     rd_en;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     claim_en;
  logic [AW-1:0]            claim_addr;
  logic                     claim_ok;
  logic [NUM_REGS-1:0]      busy_vec;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data, rd_busy, claim_ok, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_busy, claim_ok, busy_vec
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard.
//   clk, reset_n            clock, async active-low reset
//   wr_en, wr_addr          writeback clears busy of the written register
//   claim_en, claim_addr    decode claim; claim_ok is the combinational grant
//   rd_addr                 packed read addresses
//   rd_busy_next            next-state busy of each read address (what the read registers capture)
//   busy_vec                current busy bits
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter bit          ZERO_REG = 1'b0,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic                 claim_en,
  input  logic [AW-1:0]        claim_addr,
  output logic                 claim_ok,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy_next,
  output logic [NUM_REGS-1:0]  busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                claim_zero;

  assign claim_zero = ZERO_REG && (claim_addr == '0);
  // Grant looks at pre-edge state only, so a same-cycle write never unblocks a claim.
  assign claim_ok   = claim_en & (~busy_q[claim_addr] | claim_zero);

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    // Claim applied after the write clear: on a same-address collision the claim wins.
    if (claim_ok) busy_d[claim_addr] = 1'b1;
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
    assign rd_busy_next[i] = busy_d[rd_addr[i*AW +: AW]];
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with registered multi-port reads, write-to-read bypass,
// optional hardwired zero register and a busy scoreboard for RAW stalls.
//   clk, reset_n   clock, async active-low reset
//   bus (slave)    read ports, writeback port, claim port, busy_vec (see regfile_sb_if)
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_sb_if.slave  bus
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [NUM_RD-1:0] rd_busy_next;
  logic              wr_keep;

  // Writes to a hardwired zero register are dropped entirely, including from the bypass.
  assign wr_keep = bus.wr_en & ~(ZERO_REG && (bus.wr_addr == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (wr_keep) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (bus.wr_en),
    .wr_addr      (bus.wr_addr),
    .claim_en     (bus.claim_en),
    .claim_addr   (bus.claim_addr),
    .claim_ok     (bus.claim_ok),
    .rd_addr      (bus.rd_addr),
    .rd_busy_next (rd_busy_next),
    .busy_vec     (bus.busy_vec)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data_d, data_q;
    logic              busy_q;

    assign addr = bus.rd_addr[i*AW +: AW];

    always_comb begin
      data_d = regs_q[addr];
      if (wr_keep && (bus.wr_addr == addr)) data_d = bus.wr_data;
      if (ZERO_REG && (addr == '0))         data_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else if (bus.rd_en) begin
        data_q <= data_d;
        busy_q <= rd_busy_next[i];
      end
    end

    assign bus.rd_data[i*DATA_W +: DATA_W] = data_q;
    assign bus.rd_busy[i]                  = busy_q;
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2)) bus_a ();
  regfile_sb_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(3)) bus_b ();

  regfile_sb #(.DATA_W(16), .NUM_REGS(16), .NUM_RD(2), .ZERO_REG(1'b0)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  regfile_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(3), .ZERO_REG(1'b1)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model for the default configuration.
  word_t m_mem [16];
  bit    m_busy [16];
  word_t m_rd [2];
  bit    m_rb [2];

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      m_rd[p] = '0;
      m_rb[p] = 1'b0;
    end
  endtask

  function automatic logic [15:0] model_busy_vec();
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // Advances the model by one edge; returns the grant the DUT must show before the edge.
  task automatic model_step(input logic rd_en, input reg_addr_t ra0, input reg_addr_t ra1,
                            input logic wr_en, input reg_addr_t wa, input word_t wd,
                            input logic ce, input reg_addr_t ca, output logic ok);
    reg_addr_t ra [2];
    ra[0] = ra0;
    ra[1] = ra1;
    ok = ce && !m_busy[ca];
    if (wr_en) m_busy[wa] = 1'b0;
    if (ok)    m_busy[ca] = 1'b1;
    if (rd_en) begin
      for (int p = 0; p < 2; p++) begin
        m_rd[p] = (wr_en && wa == ra[p]) ? wd : m_mem[ra[p]];
        m_rb[p] = m_busy[ra[p]];
      end
    end
    if (wr_en) m_mem[wa] = wd;
  endtask

  task automatic drive_a(input logic rd_en, input reg_addr_t ra0, input reg_addr_t ra1,
                         input logic wr_en, input reg_addr_t wa, input word_t wd,
                         input logic ce, input reg_addr_t ca);
    bus_a.rd_en      = rd_en;
    bus_a.rd_addr    = {ra1, ra0};
    bus_a.wr_en      = wr_en;
    bus_a.wr_addr    = wa;
    bus_a.wr_data    = wd;
    bus_a.claim_en   = ce;
    bus_a.claim_addr = ca;
  endtask

  typedef struct {
    logic        rd_en;
    reg_addr_t   ra0, ra1;
    logic        wr_en;
    reg_addr_t   wa;
    word_t       wd;
    logic        ce;
    reg_addr_t   ca;
    logic        ok;
    word_t       rd0, rd1;
    logic [1:0]  rb;
    logic [15:0] bv;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic        ok;
    logic        r_rd, r_wr, r_ce;
    reg_addr_t   r_ra0, r_ra1, r_wa, r_ca;
    word_t       r_wd;

    //          rd  ra0   ra1   wr  wa    wd        ce  ca    ok  rd0       rd1       rb     busy_vec
    tbl[0]  = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h0000};
    tbl[1]  = '{1'b1, 4'd5, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h1234, 16'h0000, 2'b00, 16'h0000};
    tbl[2]  = '{1'b0, 4'd3, 4'd3, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h1234, 16'h0000, 2'b00, 16'h0000};
    tbl[3]  = '{1'b1, 4'd7, 4'd7, 1'b1, 4'd7, 16'hA5A5, 1'b0, 4'd0, 1'b0, 16'hA5A5, 16'hA5A5, 2'b00, 16'h0000};
    tbl[4]  = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 1'b1, 16'hA5A5, 16'hA5A5, 2'b00, 16'h0004};
    tbl[5]  = '{1'b1, 4'd2, 4'd7, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd2, 1'b0, 16'h0000, 16'hA5A5, 2'b01, 16'h0004};
    tbl[6]  = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 16'h0042, 1'b0, 4'd0, 1'b0, 16'h0000, 16'hA5A5, 2'b01, 16'h0000};
    tbl[7]  = '{1'b1, 4'd2, 4'd5, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0042, 16'h1234, 2'b00, 16'h0000};
    tbl[8]  = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 1'b1, 16'h0042, 16'h1234, 2'b00, 16'h0010};
    tbl[9]  = '{1'b1, 4'd4, 4'd4, 1'b1, 4'd4, 16'h1111, 1'b1, 4'd4, 1'b0, 16'h1111, 16'h1111, 2'b00, 16'h0000};
    tbl[10] = '{1'b1, 4'd4, 4'd4, 1'b1, 4'd4, 16'h2222, 1'b1, 4'd4, 1'b1, 16'h2222, 16'h2222, 2'b11, 16'h0010};
    tbl[11] = '{1'b1, 4'd9, 4'd4, 1'b1, 4'd4, 16'h3333, 1'b1, 4'd9, 1'b1, 16'h0000, 16'h3333, 2'b01, 16'h0200};
    tbl[12] = '{1'b0, 4'd0, 4'd0, 1'b1, 4'd4, 16'h4444, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h3333, 2'b01, 16'h0200};

    reset_n = 1'b0;
    drive_a(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    bus_b.rd_en = 1'b0; bus_b.rd_addr = '0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0;
    bus_b.wr_data = '0; bus_b.claim_en = 1'b0; bus_b.claim_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_data", 128'(bus_a.rd_data), 128'(0));
    check("reset_busy_vec", 128'(bus_a.busy_vec), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table: write/read/hold, bypass, scoreboard, collisions.
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      drive_a(tbl[k].rd_en, tbl[k].ra0, tbl[k].ra1, tbl[k].wr_en, tbl[k].wa, tbl[k].wd,
              tbl[k].ce, tbl[k].ca);
      #1;
      check($sformatf("tbl%0d_claim_ok", k), 128'(bus_a.claim_ok), 128'(tbl[k].ok));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_rd_data", k), 128'(bus_a.rd_data), 128'({tbl[k].rd1, tbl[k].rd0}));
      check($sformatf("tbl%0d_rd_busy", k), 128'(bus_a.rd_busy), 128'(tbl[k].rb));
      check($sformatf("tbl%0d_busy_vec", k), 128'(bus_a.busy_vec), 128'(tbl[k].bv));
    end

    // Reset asserted in the middle of a write of r3 (plus a claim): both must be discarded.
    @(negedge clk);
    drive_a(1'b0, '0, '0, 1'b1, 4'd3, 16'hBEEF, 1'b1, 4'd6);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_rd_data", 128'(bus_a.rd_data), 128'(0));
    check("async_reset_busy_vec", 128'(bus_a.busy_vec), 128'(0));
    @(posedge clk);
    #1;
    check("held_reset_busy_vec", 128'(bus_a.busy_vec), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    drive_a(1'b1, 4'd3, 4'd5, 1'b0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    check("post_reset_read_r3_r5", 128'(bus_a.rd_data), 128'(0));
    check("post_reset_busy_vec", 128'(bus_a.busy_vec), 128'(0));

    // Randomised traffic against the model; narrow write/claim range forces collisions.
    model_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      r_rd  = 1'($urandom_range(0, 1));
      r_ra0 = 4'($urandom_range(0, 15));
      r_ra1 = 4'($urandom_range(0, 15));
      r_wr  = 1'($urandom_range(0, 1));
      r_wa  = 4'($urandom_range(0, 7));
      r_wd  = 16'($urandom);
      r_ce  = 1'($urandom_range(0, 1));
      r_ca  = 4'($urandom_range(0, 7));
      drive_a(r_rd, r_ra0, r_ra1, r_wr, r_wa, r_wd, r_ce, r_ca);
      model_step(r_rd, r_ra0, r_ra1, r_wr, r_wa, r_wd, r_ce, r_ca, ok);
      #1;
      check($sformatf("rand%0d_claim_ok", n), 128'(bus_a.claim_ok), 128'(ok));
      @(posedge clk);
      #1;
      check($sformatf("rand%0d_rd_data", n), 128'(bus_a.rd_data), 128'({m_rd[1], m_rd[0]}));
      check($sformatf("rand%0d_rd_busy", n), 128'(bus_a.rd_busy), 128'({m_rb[1], m_rb[0]}));
      check($sformatf("rand%0d_busy_vec", n), 128'(bus_a.busy_vec), 128'(model_busy_vec()));
    end
    @(negedge clk);
    drive_a(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);

    // Hardwired zero register, wide configuration.
    @(negedge clk);
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 5'd0; bus_b.wr_data = 32'hFFFF_FFFF;
    bus_b.claim_en = 1'b1; bus_b.claim_addr = 5'd0;
    bus_b.rd_en = 1'b1; bus_b.rd_addr = {5'd0, 5'd0, 5'd0};
    #1;
    check("zr_claim_r0_ok", 128'(bus_b.claim_ok), 128'(1));
    @(posedge clk);
    #1;
    check("zr_read_r0_data", 128'(bus_b.rd_data), 128'(0));
    check("zr_read_r0_busy", 128'(bus_b.rd_busy), 128'(0));
    check("zr_busy_vec", 128'(bus_b.busy_vec), 128'(0));

    @(negedge clk);
    bus_b.wr_addr = 5'd1; bus_b.wr_data = 32'hDEAD_BEEF;
    bus_b.claim_addr = 5'd17;
    bus_b.rd_addr = {5'd17, 5'd0, 5'd1};
    #1;
    check("zr_claim_r17_ok", 128'(bus_b.claim_ok), 128'(1));
    @(posedge clk);
    #1;
    check("zr_read_mix_data", 128'(bus_b.rd_data), {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF});
    check("zr_read_mix_busy", 128'(bus_b.rd_busy), 128'(3'b100));
    check("zr_busy_vec_r17", 128'(bus_b.busy_vec), 128'(32'h0002_0000));

    @(negedge clk);
    bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0;
    bus_b.claim_addr = 5'd17;
    #1;
    check("zr_reclaim_r17_ok", 128'(bus_b.claim_ok), 128'(0));
    bus_b.claim_addr = 5'd0;
    #1;
    check("zr_reclaim_r0_ok", 128'(bus_b.claim_ok), 128'(1));
    @(posedge clk);
    #1;
    check("zr_busy_vec_final", 128'(bus_b.busy_vec), 128'(32'h0002_0000));
    @(negedge clk);
    bus_b.claim_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
